// File: rtl/v_m_c.sv
// v_m_c: single-product vending machine controller (Rs 1/2/5/10 coins).
// Optional idle-refund timeout enabled by defining VMC_TIMEOUT_EN.
module v_m_c #(
    parameter int unsigned PRICE          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Coin_01Rs,
    input  logic       Coin_02Rs,
    input  logic       Coin_05Rs,
    input  logic       Coin_10Rs,
    output logic [3:0] Change,
    output logic       Choco
);

    localparam logic [4:0] LP_PRICE = 5'(PRICE);

    logic [3:0] r_credit;
    logic [3:0] r_change;
    logic       r_choco;

    logic       w_accept;
    logic [4:0] w_value;
    logic [4:0] w_total;
    logic       w_dispense;
    logic [3:0] w_excess;
    logic       w_expire;

    // Pick the single highest-value coin; an unknown input never qualifies.
    always_comb begin
        w_accept = 1'b1;
        w_value  = 5'd0;
        if (Coin_10Rs == 1'b1) begin
            w_value = 5'd10;
        end else if (Coin_05Rs == 1'b1) begin
            w_value = 5'd5;
        end else if (Coin_02Rs == 1'b1) begin
            w_value = 5'd2;
        end else if (Coin_01Rs == 1'b1) begin
            w_value = 5'd1;
        end else begin
            w_accept = 1'b0;
        end
    end

    assign w_total    = {1'b0, r_credit} + w_value;
    assign w_dispense = w_accept && (w_total >= LP_PRICE);
    assign w_excess   = 4'(w_total - LP_PRICE);

`ifdef VMC_TIMEOUT_EN
    localparam int unsigned LP_CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LP_CW-1:0] LP_TO = LP_CW'(TIMEOUT_CYCLES);

    logic [LP_CW-1:0] r_idle;

    assign w_expire = (r_credit != 4'd0) && (r_idle == LP_TO);

    // Count idle cycles while credit is pending; any coin or refund restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_accept || r_credit == 4'd0 || w_expire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Credit accumulation, dispense and change/refund outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= 4'd0;
            r_choco  <= 1'b0;
            r_change <= 4'd0;
        end else begin
            r_choco  <= 1'b0;
            r_change <= 4'd0;
            if (w_dispense) begin
                r_choco  <= 1'b1;
                r_change <= w_excess;
                r_credit <= 4'd0;
            end else if (w_accept) begin
                r_credit <= w_total[3:0];
            end else if (w_expire) begin
                r_change <= r_credit;
                r_credit <= 4'd0;
            end
        end
    end

    assign Choco  = r_choco;
    assign Change = r_change;

endmodule

// File: tb/tb_v_m_c.sv
// tb_v_m_c: directed and random coin sequences against a rupee-level model.
// Timeout checks are active when VMC_TIMEOUT_EN is defined.
module tb_v_m_c;

    localparam int P  = 5;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       Coin_01Rs;
    logic       Coin_02Rs;
    logic       Coin_05Rs;
    logic       Coin_10Rs;
    logic [3:0] Change;
    logic       Choco;

    int n_cmp = 0;
    int n_bad = 0;

    int m_credit = 0;
    int m_idle   = 0;
    int e_choco  = 0;
    int e_change = 0;

    v_m_c #(.PRICE(P), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .Coin_01Rs (Coin_01Rs),
        .Coin_02Rs (Coin_02Rs),
        .Coin_05Rs (Coin_05Rs),
        .Coin_10Rs (Coin_10Rs),
        .Change    (Change),
        .Choco     (Choco)
    );

    always #5 clk = ~clk;

    // Rupee-level reference: c = {Rs10, Rs5, Rs2, Rs1}.
    task automatic model(input logic r, input logic [3:0] c);
        int v;
        e_choco  = 0;
        e_change = 0;
        if (r) begin
            m_credit = 0;
            m_idle   = 0;
            return;
        end
        v = c[3] ? 10 : c[2] ? 5 : c[1] ? 2 : c[0] ? 1 : 0;
        if (v != 0) begin
            m_idle = 0;
            if (m_credit + v >= P) begin
                e_choco  = 1;
                e_change = m_credit + v - P;
                m_credit = 0;
            end else begin
                m_credit = m_credit + v;
            end
        end else begin
`ifdef VMC_TIMEOUT_EN
            if (m_credit == 0) begin
                m_idle = 0;
            end else if (m_idle == TO) begin
                e_change = m_credit;
                m_credit = 0;
                m_idle   = 0;
            end else begin
                m_idle++;
            end
`endif
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] c);
        rst = r;
        {Coin_10Rs, Coin_05Rs, Coin_02Rs, Coin_01Rs} = c;
        @(posedge clk);
        #1;
        model(r, c);
        n_cmp++;
        assert (Choco === 1'(e_choco)) else begin
            n_bad++;
            $error("FAIL %s choco got %0d want %0d", tag, Choco, e_choco);
        end
        n_cmp++;
        assert (Change === 4'(e_change)) else begin
            n_bad++;
            $error("FAIL %s change got %0d want %0d", tag, Change, e_change);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        {Coin_10Rs, Coin_05Rs, Coin_02Rs, Coin_01Rs} = 4'b0000;
        #1;
        step("reset0", 1'b1, 4'b0000);
        step("reset1", 1'b1, 4'b0000);
        step("idle0", 1'b0, 4'b0000);

        step("rs10", 1'b0, 4'b1000);
        step("rs10_after", 1'b0, 4'b0000);
        idle("gap", 2);

        step("rs2a", 1'b0, 4'b0010);
        idle("gap2a", 12);
        step("rs2b", 1'b0, 4'b0010);
        idle("gap2b", 12);
        step("rs1_exact", 1'b0, 4'b0001);
        step("exact_after", 1'b0, 4'b0000);

        step("c4_a", 1'b0, 4'b0010);
        step("c4_b", 1'b0, 4'b0010);
        step("c4_rs10", 1'b0, 4'b1000);
        step("c4_after", 1'b0, 4'b0000);

        step("sim_10_1", 1'b0, 4'b1001);
        step("sim_after", 1'b0, 4'b0000);
        step("sim_all", 1'b0, 4'b1111);
        step("sim_5_2", 1'b0, 4'b0110);

        step("c3_a", 1'b0, 4'b0010);
        step("c3_b", 1'b0, 4'b0001);
        step("mid_rst", 1'b1, 4'b0101);
        step("post_rst2", 1'b0, 4'b0010);
        step("post_rst2b", 1'b0, 4'b0010);
        step("post_rst1", 1'b0, 4'b0001);

        step("b2b_5a", 1'b0, 4'b0100);
        step("b2b_5b", 1'b0, 4'b0100);
        step("b2b_hold2", 1'b0, 4'b0010);
        step("b2b_hold2", 1'b0, 4'b0010);
        step("b2b_hold2", 1'b0, 4'b0010);
        idle("b2b_gap", 2);

        step("to_rs1", 1'b0, 4'b0001);
        idle("to_idle", TO + 4);
        step("to_rs2", 1'b0, 4'b0010);
        idle("to_idle2", TO);
        step("to_expiry_coin", 1'b0, 4'b0001);
        idle("to_idle3", TO + 3);
        step("rst_clear", 1'b1, 4'b0000);

        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [3:0] c;
            r = ($urandom_range(0, 59) == 0);
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step("rand", r, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
